rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/threadbrain_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/rf_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/threadbrain_pkg.sv
// Shared definitions for the thread-brain register-file blocks.
// Holds the register-file entry layout (field offsets and widths) and the
// write-back FSM state encoding used by rf_wb_arbiter.
package threadbrain_pkg;

    // Entry layout, MSB to LSB: valid | locked | dirty | ptr[15:0] | val[15:0]
    localparam int RF_ENTRY_W    = 35;
    localparam int RF_VALID_BIT  = 34;
    localparam int RF_LOCKED_BIT = 33;
    localparam int RF_DIRTY_BIT  = 32;
    localparam int RF_PTR_LSB    = 16;
    localparam int RF_PTR_W      = 16;
    localparam int RF_VAL_LSB    = 0;
    localparam int RF_VAL_W      = 16;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WRITE = 2'd1,
        WB_DONE  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// modulo N. Purely combinational so schedulers can register as they need.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the highest-priority requester this round
//   grant - one-hot grant (all zero when nothing requests)
//   valid - at least one requester was granted
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    localparam logic [PW:0] N_W = (PW+1)'(N);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            idx = sum[PW-1:0];
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter. Cores request a flush of their cell; one
// flush at a time is granted round-robin, dirty cells are written to the
// shared data-memory port, and the cell is handed back unlocked and clean.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   rf_in       - register file, entry i at [i*ENTRY_W +: ENTRY_W]
//   flush_req   - level flush request per core
//   mem_we      - memory write strobe (held until mem_ack)
//   mem_addr    - write address (latched entry ptr)
//   mem_wdata   - write data (latched entry val)
//   mem_ack     - memory accepted the write
//   rf_out      - registered register file with the flushed entry cleaned
//   flush_done  - one-cycle completion pulse per core
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WB_IDLE  | no flush in flight; grant next eligible core round-robin
// WB_WRITE | memory write of latched ptr/val, waiting for mem_ack
// WB_DONE  | pulse flush_done[g], clean entry g, advance rr pointer
module rf_wb_arbiter
    import threadbrain_pkg::*;
#(
    parameter int NCORES  = 4,
    parameter int ENTRY_W = RF_ENTRY_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NCORES*ENTRY_W-1:0]   rf_in,
    input  logic [NCORES-1:0]           flush_req,
    output logic                        mem_we,
    output logic [RF_PTR_W-1:0]         mem_addr,
    output logic [RF_VAL_W-1:0]         mem_wdata,
    input  logic                        mem_ack,
    output logic [NCORES*ENTRY_W-1:0]   rf_out,
    output logic [NCORES-1:0]           flush_done
);

    localparam int GW = (NCORES > 1) ? $clog2(NCORES) : 1;

    wb_state_e             state, state_nxt;
    logic [NCORES-1:0]     eligible;
    logic [NCORES-1:0]     grant;
    logic                  grant_valid;
    logic [GW-1:0]         grant_idx;
    logic [GW-1:0]         g_q;
    logic [GW-1:0]         rr_ptr;
    logic [RF_PTR_W-1:0]   sel_ptr;
    logic [RF_VAL_W-1:0]   sel_val;
    logic                  sel_dirty;
    logic [RF_PTR_W-1:0]   addr_q;
    logic [RF_VAL_W-1:0]   data_q;
    logic [NCORES*ENTRY_W-1:0] rf_next;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NCORES; i++) begin
            eligible[i] = flush_req[i] & rf_in[i*ENTRY_W + RF_VALID_BIT];
        end
    end

    rr_arbiter #(
        .N  (NCORES),
        .PW (GW)
    ) u_rr (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    // One-hot grant to index plus the granted entry's fields.
    always_comb begin
        grant_idx = '0;
        sel_ptr   = '0;
        sel_val   = '0;
        sel_dirty = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            if (grant[i]) begin
                grant_idx = GW'(i);
                sel_ptr   = rf_in[i*ENTRY_W + RF_PTR_LSB +: RF_PTR_W];
                sel_val   = rf_in[i*ENTRY_W + RF_VAL_LSB +: RF_VAL_W];
                sel_dirty = rf_in[i*ENTRY_W + RF_DIRTY_BIT];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE: begin
                if (grant_valid) begin
                    state_nxt = sel_dirty ? WB_WRITE : WB_DONE;
                end
            end
            WB_WRITE: begin
                if (mem_ack) begin
                    state_nxt = WB_DONE;
                end
            end
            WB_DONE:  state_nxt = WB_IDLE;
            default:  state_nxt = WB_IDLE;
        endcase
    end

    // The cleaned entry shows on rf_out in the cycle after DONE only; the
    // owning core is expected to update its own copy of the cell.
    always_comb begin
        rf_next    = rf_in;
        flush_done = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (state == WB_DONE && g_q == GW'(i)) begin
                rf_next[i*ENTRY_W + RF_LOCKED_BIT] = 1'b0;
                rf_next[i*ENTRY_W + RF_DIRTY_BIT]  = 1'b0;
                flush_done[i]                      = 1'b1;
            end
        end
    end

    assign mem_we    = (state == WB_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= WB_IDLE;
            rr_ptr <= '0;
            g_q    <= '0;
            addr_q <= '0;
            data_q <= '0;
            rf_out <= '0;
        end else begin
            state  <= state_nxt;
            rf_out <= rf_next;
            if (state == WB_IDLE && grant_valid) begin
                g_q    <= grant_idx;
                addr_q <= sel_ptr;
                data_q <= sel_val;
            end
            if (state == WB_DONE) begin
                rr_ptr <= (g_q == GW'(NCORES-1)) ? '0 : g_q + GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level round-robin model.
module tb_rf_wb_arbiter;

    localparam int NC = 4;
    localparam int EW = 35;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*EW-1:0]  rf_in;
    logic [NC*EW-1:0]  rf_out;
    logic [NC-1:0]     flush_req;
    logic [NC-1:0]     flush_done;
    logic              mem_we;
    logic              mem_ack;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;

    int errors = 0;
    int checks = 0;

    rf_wb_arbiter #(
        .NCORES  (NC),
        .ENTRY_W (EW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rf_in      (rf_in),
        .flush_req  (flush_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .rf_out     (rf_out),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input logic v, input logic l, input logic d,
                                         input logic [15:0] p, input logic [15:0] val);
        return {v, l, d, p, val};
    endfunction

    function automatic logic [NC*EW-1:0] cleaned(input logic [NC*EW-1:0] v, input int g);
        logic [NC*EW-1:0] r;
        r = v;
        r[g*EW + 33] = 1'b0;
        r[g*EW + 32] = 1'b0;
        return r;
    endfunction

    function automatic logic [EW-1:0] rand_entry();
        return mk(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rf_in = {NC{mk(1'b1, 1'b1, 1'b1, 16'h5A5A, 16'hA5A5)}};
        flush_req = '1;
        mem_ack = 1'b1;
        tick();
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
        checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0000", mem_wdata); end
        checks++; if (flush_done !== 4'b0) begin errors++; $display("FAIL reset_flush_done: got %b expected 0000", flush_done); end
        checks++; if (rf_out !== '0) begin errors++; $display("FAIL reset_rf_out: got %h expected 0", rf_out); end
        rf_in = '0;
        flush_req = '0;
        mem_ack = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_flush();
        logic [NC*EW-1:0] exp_rf;
        rf_in = '0;
        rf_in[1*EW +: EW] = mk(1'b1, 1'b1, 1'b1, 16'h0010, 16'h00AB);
        flush_req = 4'b0010;
        mem_ack = 1'b1;
        tick();
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", mem_we); end
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL single_addr: got %h expected 0010", mem_addr); end
        checks++; if (mem_wdata !== 16'h00AB) begin errors++; $display("FAIL single_data: got %h expected 00ab", mem_wdata); end
        tick();
        checks++; if (flush_done !== 4'b0010) begin errors++; $display("FAIL single_done: got %b expected 0010", flush_done); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_off: got %b expected 0", mem_we); end
        flush_req = '0;
        mem_ack = 1'b0;
        exp_rf = cleaned(rf_in, 1);
        tick();
        checks++; if (rf_out !== exp_rf) begin errors++; $display("FAIL single_rf_out: got %h expected %h", rf_out, exp_rf); end
        checks++; if (flush_done !== 4'b0) begin errors++; $display("FAIL single_done_once: got %b expected 0000", flush_done); end
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_idle_we: got %b expected 0", mem_we); end
    endtask

    // rr_ptr is 2 here; only core0 is eligible so selection must wrap.
    task automatic test_clean_entry();
        rf_in = '0;
        rf_in[0 +: EW] = mk(1'b1, 1'b1, 1'b0, 16'h1234, 16'h5678);
        flush_req = 4'b0001;
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL clean_no_we: got %b expected 0", mem_we); end
        checks++; if (flush_done !== 4'b0001) begin errors++; $display("FAIL clean_done: got %b expected 0001", flush_done); end
        flush_req = '0;
        tick();
        checks++; if (flush_done !== 4'b0) begin errors++; $display("FAIL clean_done_once: got %b expected 0000", flush_done); end
        checks++; if (rf_out[0 +: EW] !== mk(1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678))
            begin errors++; $display("FAIL clean_rf_out: got %h expected unlocked entry0", rf_out[0 +: EW]); end
    endtask

    task automatic test_backpressure();
        int pulses;
        rf_in = '0;
        rf_in[2*EW +: EW] = mk(1'b1, 1'b0, 1'b1, 16'hBEEF, 16'hCAFE);
        flush_req = 4'b0100;
        mem_ack = 1'b0;
        tick();
        for (int c = 0; c < 6; c++) begin
            checks++; if (mem_we !== 1'b1 || mem_addr !== 16'hBEEF || mem_wdata !== 16'hCAFE)
                begin errors++; $display("FAIL bp_hold c%0d: got we=%b %h/%h expected 1 beef/cafe", c, mem_we, mem_addr, mem_wdata); end
            checks++; if (flush_done !== 4'b0) begin errors++; $display("FAIL bp_early_done c%0d: got %b expected 0000", c, flush_done); end
            rf_in[2*EW +: EW] = rand_entry();
            if (c == 1) flush_req = '0;
            mem_ack = (c == 5);
            tick();
        end
        mem_ack = 1'b0;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            if (flush_done === 4'b0100) pulses++;
            tick();
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL bp_pulses: got %0d expected 1", pulses); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL bp_we_after: got %b expected 0", mem_we); end
    endtask

    task automatic test_fairness();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < NC; i++) rf_in[i*EW +: EW] = mk(1'b1, 1'b1, 1'b1, 16'h0100 + 16'(i), 16'h0200 + 16'(i));
        flush_req = 4'b1111;
        mem_ack = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0100 + 16'(order[n]))
                begin errors++; $display("FAIL fair_grant n%0d: got we=%b addr %h expected addr %h", n, mem_we, mem_addr, 16'h0100 + 16'(order[n])); end
            tick();
            checks++; if (flush_done !== 4'(1 << order[n]))
                begin errors++; $display("FAIL fair_done n%0d: got %b expected %b", n, flush_done, 4'(1 << order[n])); end
            tick();
        end
        flush_req = '0;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        for (int i = 0; i < NC; i++) rf_in[i*EW +: EW] = mk(1'b1, 1'b1, 1'b1, 16'h0300 + 16'(i), 16'h0400 + 16'(i));
        flush_req = 4'b1000;
        mem_ack = 1'b0;
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0303)
            begin errors++; $display("FAIL rmw_write: got we=%b addr %h expected 1 0303", mem_we, mem_addr); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmw_we: got %b expected 0", mem_we); end
        checks++; if (flush_done !== 4'b0) begin errors++; $display("FAIL rmw_done: got %b expected 0000", flush_done); end
        rst = 1'b0;
        flush_req = '0;
        tick();
        checks++; if (flush_done !== 4'b0) begin errors++; $display("FAIL rmw_no_pulse: got %b expected 0000", flush_done); end
        flush_req = 4'b1111;
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0300)
            begin errors++; $display("FAIL rmw_fresh: got we=%b addr %h expected 1 0300", mem_we, mem_addr); end
        mem_ack = 1'b1;
        tick();
        checks++; if (flush_done !== 4'b0001) begin errors++; $display("FAIL rmw_fresh_done: got %b expected 0001", flush_done); end
        flush_req = '0;
        mem_ack = 1'b0;
        tick();
    endtask

    // Model: grant = first eligible core at/after model_rr; a dirty grant
    // writes its (ptr,val) until acked, then one done pulse; rf_out is rf_in
    // one cycle late except the granted entry cleaned after the pulse.
    task automatic test_random();
        int model_rr;
        int g;
        int w;
        logic [NC-1:0]    elig;
        logic [NC*EW-1:0] prev_rf;
        logic             dirty;
        logic [15:0]      exp_addr, exp_data;
        do_reset();
        mem_ack = 1'b0;
        model_rr = 0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NC; i++) rf_in[i*EW +: EW] = rand_entry();
            flush_req = 4'($urandom);
            elig = '0;
            for (int i = 0; i < NC; i++) elig[i] = flush_req[i] & rf_in[i*EW + 34];
            if (elig == '0) begin
                g = int'($urandom_range(0, NC-1));
                rf_in[g*EW + 34] = 1'b1;
                flush_req[g] = 1'b1;
                elig[g] = 1'b1;
            end
            g = -1;
            for (int k = 0; k < NC; k++) begin
                if (g < 0 && elig[(model_rr + k) % NC]) g = (model_rr + k) % NC;
            end
            dirty    = rf_in[g*EW + 32];
            exp_addr = rf_in[g*EW + 16 +: 16];
            exp_data = rf_in[g*EW +: 16];
            mem_ack  = 1'($urandom);
            prev_rf  = rf_in;
            tick();
            checks++; if (rf_out !== prev_rf) begin errors++; $display("FAIL rnd_pass t%0d: got %h expected %h", t, rf_out, prev_rf); end
            if (dirty) begin
                w = int'($urandom_range(0, 3));
                for (int c = 0; c <= w; c++) begin
                    checks++; if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== exp_data || flush_done !== 4'b0)
                        begin errors++; $display("FAIL rnd_write t%0d c%0d: got we=%b %h/%h done=%b expected 1 %h/%h 0000",
                                                 t, c, mem_we, mem_addr, mem_wdata, flush_done, exp_addr, exp_data); end
                    rf_in[g*EW +: EW] = rand_entry();
                    flush_req = 4'($urandom);
                    mem_ack = (c == w);
                    prev_rf = rf_in;
                    tick();
                    checks++; if (rf_out !== prev_rf) begin errors++; $display("FAIL rnd_pass_w t%0d: got %h expected %h", t, rf_out, prev_rf); end
                end
            end
            checks++; if (flush_done !== 4'(1 << g) || mem_we !== 1'b0)
                begin errors++; $display("FAIL rnd_done t%0d: got done=%b we=%b expected %b 0", t, flush_done, mem_we, 4'(1 << g)); end
            for (int i = 0; i < NC; i++) rf_in[i*EW +: EW] = rand_entry();
            mem_ack = 1'($urandom);
            prev_rf = rf_in;
            tick();
            checks++; if (rf_out !== cleaned(prev_rf, g))
                begin errors++; $display("FAIL rnd_clean t%0d: got %h expected %h", t, rf_out, cleaned(prev_rf, g)); end
            checks++; if (flush_done !== 4'b0 || mem_we !== 1'b0)
                begin errors++; $display("FAIL rnd_idle t%0d: got done=%b we=%b expected 0000 0", t, flush_done, mem_we); end
            model_rr = (g + 1) % NC;
        end
        flush_req = '0;
        mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rf_in = '0;
        flush_req = '0;
        mem_ack = 1'b0;
        test_reset();
        test_single_flush();
        test_clean_entry();
        test_backpressure();
        test_fairness();
        test_reset_mid_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
